fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the RV32I core, sitting directly upstream of the control decoder. It owns the program counter, issues one instruction-memory request at a time, and captures the returned word into an IF/ID holding register. It classifies the opcode into the one-hot type strobes the control decoder consumes (r_type … lui, func3, func7), and hands the instruction downstream over a valid/ready handshake. Redirects from branch/jump resolution flush it.

## Interface
- RESET_PC, 32'h0000_0000: PC fetched first after reset
- XLEN, 32: address/data width; only 32 supported
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response strobe, one per accepted request, ≥1 cycle after acceptance
- imem_rsp_data  in  XLEN  instruction word
- redirect_valid  in  1  control-flow change
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored (treated as 0)
- id_valid  out  1  IF/ID register holds an instruction
- id_ready  in  1  downstream consumes it
- id_pc, id_instr  out  XLEN each  PC and word of the held instruction
- r_type, i_type, load, store, branch, jal, jalr, auipc, lui  out  1 each  opcode class, one-hot, 0 when id_valid=0
- illegal  out  1  id_valid and opcode matches no class
- func3  out  3  id_instr[14:12]; func7  out  1  id_instr[30]
- rs1, rs2, rd  out  5 each  id_instr[19:15], [24:20], [11:7]

## Operation
- States: IDLE, FETCH, WAIT, HOLD, DRAIN.
- IDLE: entered by reset; next cycle → FETCH.
- FETCH: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready → WAIT.
- WAIT: on imem_rsp_valid capture id_instr←imem_rsp_data, id_pc←pc, pc←pc+4 → HOLD.
- HOLD: id_valid=1; on id_ready → FETCH.
- DRAIN: discard one pending response; on imem_rsp_valid → FETCH, nothing captured.
- Redirect (highest priority, any non-IDLE state): pc←{redirect_pc[31:2],2'b00}, id_valid cleared next cycle. Next state DRAIN if a request is outstanding (WAIT, or FETCH with imem_req_ready this cycle), else FETCH. Redirect in DRAIN: pc updated, stay DRAIN.
- Redirect and id_ready same cycle in HOLD: instruction counts as consumed; redirect still applies.
- Class decode on id_instr[6:0]: 0110011 r_type, 0010011 i_type, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr, 0010111 auipc, 0110111 lui; all else illegal.
- pc increments modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).

## Timing
- Reset values: state IDLE, pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_pc=0, id_instr=0 (32'h0000_0013 not required), all class strobes/illegal=0.
- rst_n low mid-operation: all state reset at next edge; outstanding memory response after reset ignored (IDLE/FETCH do not capture).
- First request asserted cycle 2 after rst_n deasserts (IDLE 1 cycle).
- Latency: request accept → response N cycles → id_valid the cycle after response.
- Throughput with 1-cycle memory and id_ready=1: one instruction per 3 cycles.
- imem_req_valid, once asserted, stays with stable address until accepted or redirect.
- id_* and decode outputs stable while id_valid=1 and id_ready=0.
- Decode outputs combinational from id_instr/id_valid; all other outputs registered or state-decoded.

## Structure
- Shared package rv32i_pkg: opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI), fetch state encoding.
- Sub-module opcode_classifier: 7-bit opcode + valid → nine one-hot strobes + illegal.

## Test plan
- Reset, RESET_PC=0x100, 1-cycle memory, id_ready=1 → requests 0x100, 0x104, 0x108; id_pc matches; one id_valid pulse per 3 cycles.
- imem_rsp_data=0x00A00093 (addi) → i_type=1, func3=0, rd=1, rs1=0, others 0; 0xFFFFFFFF → illegal=1.
- id_ready low 5 cycles in HOLD → id_instr/id_pc stable, no new imem_req_valid.
- Redirect to 0x200 in WAIT, stale response arrives 2 cycles later → response dropped, next request addr 0x200, id_valid never shows stale word.
- Redirect to 0x303 with id_ready same cycle in HOLD → next request 0x300, id_valid 0 next cycle.
- rst_n low during WAIT, response arrives after reset → not captured; first request at RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the front end.
// Holds the base opcode encodings used by the class decoder and the
// state encoding of the fetch controller.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/opcode_classifier.sv
// Opcode class decoder.
// Maps a 7-bit RV32I major opcode to one-hot class strobes. All strobes,
// including illegal, are forced low when valid is low.
// Ports:
//   opcode  in   7  major opcode (instr[6:0])
//   valid   in   1  opcode belongs to a held instruction
//   r_type .. lui  out 1 each  one-hot class
//   illegal out  1  valid and no class matched
module opcode_classifier
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic       valid,
  output logic       r_type,
  output logic       i_type,
  output logic       load,
  output logic       store,
  output logic       branch,
  output logic       jal,
  output logic       jalr,
  output logic       auipc,
  output logic       lui,
  output logic       illegal
);

  always_comb begin
    r_type  = 1'b0;
    i_type  = 1'b0;
    load    = 1'b0;
    store   = 1'b0;
    branch  = 1'b0;
    jal     = 1'b0;
    jalr    = 1'b0;
    auipc   = 1'b0;
    lui     = 1'b0;
    illegal = 1'b0;
    if (valid) begin
      case (opcode)
        OP_R:      r_type  = 1'b1;
        OP_I:      i_type  = 1'b1;
        OP_LOAD:   load    = 1'b1;
        OP_STORE:  store   = 1'b1;
        OP_BRANCH: branch  = 1'b1;
        OP_JAL:    jal     = 1'b1;
        OP_JALR:   jalr    = 1'b1;
        OP_AUIPC:  auipc   = 1'b1;
        OP_LUI:    lui     = 1'b1;
        default:   illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage.
// Owns the PC, issues one instruction-memory request at a time, captures
// the returned word into the IF/ID register and presents it downstream
// over valid/ready together with its decoded fields and opcode class.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   imem_req_valid/ready/addr           fetch request channel
//   imem_rsp_valid/data                 fetch response (one per accepted request)
//   redirect_valid/redirect_pc          control-flow change, flushes the stage
//   id_valid/id_ready/id_pc/id_instr    IF/ID handshake and held instruction
//   r_type..lui, illegal                opcode class strobes
//   func3, func7, rs1, rs2, rd          instruction fields of id_instr
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// FETCH | request for pc is presented to memory
// WAIT  | request accepted, waiting for its response
// HOLD  | IF/ID register valid, waiting for downstream to take it
// DRAIN | a redirect orphaned a request; swallow its response
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            r_type,
  output logic            i_type,
  output logic            load,
  output logic            store,
  output logic            branch,
  output logic            jal,
  output logic            jalr,
  output logic            auipc,
  output logic            lui,
  output logic            illegal,
  output logic [2:0]      func3,
  output logic            func7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] id_pc_q, id_instr_q;
  logic [XLEN-1:0] redirect_target;
  logic            capture;

  // Redirect targets are forced to word alignment; the low bits are dropped.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (capture) begin
        id_pc_q    <= pc_q;
        id_instr_q <= imem_rsp_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          // A request accepted on this very edge still owes us a response.
          state_d = imem_req_ready ? ST_DRAIN : ST_FETCH;
        end else if (imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          // If the response lands together with the redirect it is simply
          // dropped here; nothing is left to drain.
          state_d = imem_rsp_valid ? ST_FETCH : ST_DRAIN;
        end else if (imem_rsp_valid) begin
          capture = 1'b1;
          pc_d    = pc_q + XLEN'(4);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = ST_FETCH;
        end else if (id_ready) begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end
        if (imem_rsp_valid) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_req_valid = (state_q == ST_FETCH);
  assign imem_req_addr  = pc_q;
  assign id_valid       = (state_q == ST_HOLD);
  assign id_pc          = id_pc_q;
  assign id_instr       = id_instr_q;

  assign func3 = id_instr_q[14:12];
  assign func7 = id_instr_q[30];
  assign rs1   = id_instr_q[19:15];
  assign rs2   = id_instr_q[24:20];
  assign rd    = id_instr_q[11:7];

  opcode_classifier u_classifier (
    .opcode  (id_instr_q[6:0]),
    .valid   (id_valid),
    .r_type  (r_type),
    .i_type  (i_type),
    .load    (load),
    .store   (store),
    .branch  (branch),
    .jal     (jal),
    .jalr    (jalr),
    .auipc   (auipc),
    .lui     (lui),
    .illegal (illegal)
  );

endmodule
